cv32e40p_alu_tmr_scheduler_ft: RTL and testbench

- Issue-side scheduler for the four redundant EX-stage ALUs.
- Per operation, picks which ALUs execute and feeds the three voter input selects.
- Uses the per-class permanent-fault map from the ALU error counters to skip damaged ALUs and degrade TMR -> DMR -> single -> none.
- Rotates the spare ALU in full-health TMR so every ALU keeps being checked, and sequences a bounded replay when a DMR pair disagrees.

---
 rtl/cv32e40p_alu_tmr_scheduler_ft.sv | 173 +++++++++++++++++
 tb/tb_cv32e40p_alu_tmr_scheduler_ft.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_alu_tmr_scheduler_ft.sv
// rtl/cv32e40p_alu_tmr_scheduler_ft.sv - issue-side scheduler for the four redundant EX-stage ALUs
module cv32e40p_alu_tmr_scheduler_ft #(
    parameter int MAX_RETRY = 1,
    parameter int NUM_CLASS = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid_i,
    output logic                   issue_ready_o,
    input  logic [3:0]             op_class_i,
    input  logic [4*NUM_CLASS-1:0] permanent_faulty_i,
    input  logic                   ex_done_i,
    input  logic                   vote_mismatch_i,
    output logic [3:0]             alu_enable_o,
    output logic [5:0]             alu_sel_o,
    output logic [1:0]             mode_o,
    output logic                   replay_o,
    output logic [3:0]             counter_clk_en_o,
    output logic                   dmr_unrecoverable_o,
    output logic                   alu_fail_o
);

    typedef enum logic [1:0] {IDLE, EXEC, RETRY, ERR} state_t;

    localparam logic [1:0] MODE_TMR    = 2'b00;
    localparam logic [1:0] MODE_DMR    = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;
    localparam logic [1:0] MODE_NONE   = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] sp_q, sp_d;
    logic [1:0] retry_q, retry_d;
    logic [3:0] en_q, en_d;
    logic [5:0] sel_q, sel_d;
    logic [1:0] mode_q, mode_d;
    logic       replay_q, replay_d;
    logic       fail_q, fail_d;

    logic       alu_op;
    logic [3:0] healthy;
    logic [3:0] pick;
    logic [2:0] n_healthy;
    logic [1:0] idx [4];
    logic [5:0] new_sel;
    logic [1:0] new_mode;
    logic       exec_ok;
    logic       accept;
    int         k;

    // Selection for the op presented this cycle; it is latched on acceptance,
    // which also snapshots the fault map for the lifetime of the op.
    always_comb begin
        alu_op    = (int'(op_class_i) < NUM_CLASS);
        healthy   = 4'b0000;
        n_healthy = 3'd0;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < NUM_CLASS; c++) begin
                if (alu_op && op_class_i == 4'(c)) begin
                    healthy[i] = ~permanent_faulty_i[i*NUM_CLASS+c];
                end
            end
            n_healthy = n_healthy + {2'b00, healthy[i]};
        end
        pick = healthy;
        if (n_healthy == 3'd4) begin
            pick[sp_q] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            idx[i] = 2'd0;
        end
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (pick[i]) begin
                idx[k[1:0]] = 2'(i);
                k = k + 1;
            end
        end
        case (n_healthy)
            3'd4, 3'd3: begin new_sel = {idx[2], idx[1], idx[0]}; new_mode = MODE_TMR;    end
            3'd2:       begin new_sel = {idx[0], idx[1], idx[0]}; new_mode = MODE_DMR;    end
            3'd1:       begin new_sel = {idx[0], idx[0], idx[0]}; new_mode = MODE_SINGLE; end
            default:    begin new_sel = 6'd0;                     new_mode = MODE_NONE;   end
        endcase
    end

    assign exec_ok       = (state_q == EXEC) && ex_done_i && !((mode_q == MODE_DMR) && vote_mismatch_i);
    assign issue_ready_o = !rst && ((state_q == IDLE) || exec_ok);
    assign accept        = issue_valid_i && issue_ready_o;

    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        retry_d  = retry_q;
        en_d     = en_q;
        sel_d    = sel_q;
        mode_d   = mode_q;
        replay_d = replay_q;
        fail_d   = 1'b0;
        case (state_q)
            IDLE, EXEC: begin
                if (state_q == EXEC && ex_done_i && !exec_ok) begin
                    state_d = (int'(retry_q) < MAX_RETRY) ? RETRY : ERR;
                end else if (accept) begin
                    retry_d  = 2'd0;
                    replay_d = 1'b0;
                    state_d  = IDLE;
                    if (alu_op) begin
                        sel_d  = new_sel;
                        en_d   = pick;
                        mode_d = new_mode;
                        if (n_healthy == 3'd4) begin
                            sp_d = sp_q + 2'd1;
                        end
                        if (n_healthy == 3'd0) begin
                            fail_d = 1'b1;
                        end else begin
                            state_d = EXEC;
                        end
                    end
                end else if (exec_ok) begin
                    state_d = IDLE;
                end
            end
            RETRY: begin
                retry_d  = retry_q + 2'd1;
                replay_d = 1'b1;
                state_d  = EXEC;
            end
            ERR: begin
                retry_d = 2'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sp_q     <= 2'd0;
            retry_q  <= 2'd0;
            en_q     <= 4'd0;
            sel_q    <= 6'd0;
            mode_q   <= MODE_NONE;
            replay_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            retry_q  <= retry_d;
            en_q     <= en_d;
            sel_q    <= sel_d;
            mode_q   <= mode_d;
            replay_q <= replay_d;
            fail_q   <= fail_d;
        end
    end

    assign alu_enable_o        = (state_q == EXEC) ? en_q : 4'd0;
    assign alu_sel_o           = sel_q;
    assign mode_o              = mode_q;
    assign replay_o            = (state_q == EXEC) && replay_q;
    assign dmr_unrecoverable_o = (state_q == ERR);
    assign alu_fail_o          = fail_q;

    // An ALU broken in every class can never be trusted again; freeze its counters.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            counter_clk_en_o[i] = !rst && !(&permanent_faulty_i[i*NUM_CLASS +: NUM_CLASS]);
        end
    end

endmodule

// File: tb/tb_cv32e40p_alu_tmr_scheduler_ft.sv
// tb/tb_cv32e40p_alu_tmr_scheduler_ft.sv - self-checking bench for the ALU TMR scheduler
module tb_cv32e40p_alu_tmr_scheduler_ft;

    localparam int MAX_RETRY = 1;
    localparam int NC        = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [3:0]  op_class_i;
    logic [35:0] pf;
    logic        ex_done_i;
    logic        vote_mismatch_i;
    logic [3:0]  alu_enable_o;
    logic [5:0]  alu_sel_o;
    logic [1:0]  mode_o;
    logic        replay_o;
    logic [3:0]  counter_clk_en_o;
    logic        dmr_unrecoverable_o;
    logic        alu_fail_o;

    int total = 0;
    int bad   = 0;
    int sp_m  = 0;
    logic [1:0] mode_m = 2'b11;

    cv32e40p_alu_tmr_scheduler_ft #(.MAX_RETRY(MAX_RETRY), .NUM_CLASS(NC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .issue_valid_i       (issue_valid_i),
        .issue_ready_o       (issue_ready_o),
        .op_class_i          (op_class_i),
        .permanent_faulty_i  (pf),
        .ex_done_i           (ex_done_i),
        .vote_mismatch_i     (vote_mismatch_i),
        .alu_enable_o        (alu_enable_o),
        .alu_sel_o           (alu_sel_o),
        .mode_o              (mode_o),
        .replay_o            (replay_o),
        .counter_clk_en_o    (counter_clk_en_o),
        .dmr_unrecoverable_o (dmr_unrecoverable_o),
        .alu_fail_o          (alu_fail_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: list healthy ALUs, drop the spare in full health, route by list length.
    function automatic void model(input logic [35:0] map, input int cls, input int sp,
                                  output logic [5:0] sel, output logic [3:0] en,
                                  output logic [1:0] mode, output int n);
        int q[$];
        for (int i = 0; i < 4; i++) if (!map[i*NC+cls]) q.push_back(i);
        n = q.size();
        if (n == 4) q.delete(sp);
        en = 4'd0;
        foreach (q[j]) en[q[j]] = 1'b1;
        case (n)
            4, 3:    begin sel = {2'(q[2]), 2'(q[1]), 2'(q[0])}; mode = 2'b00; end
            2:       begin sel = {2'(q[0]), 2'(q[1]), 2'(q[0])}; mode = 2'b01; end
            1:       begin sel = {2'(q[0]), 2'(q[0]), 2'(q[0])}; mode = 2'b10; end
            default: begin sel = 6'd0; mode = 2'b11; end
        endcase
    endfunction

    task automatic accept_op(input int cls);
        op_class_i    = 4'(cls);
        issue_valid_i = 1'b1;
        tick();
        issue_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; issue_valid_i = 1'b1; op_class_i = 4'd0; pf = '0;
        ex_done_i = 1'b0; vote_mismatch_i = 1'b0;
        tick(); tick();
        total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", issue_ready_o); end
        total++; if (mode_o !== 2'b11) begin bad++; $display("FAIL reset_mode got=%b exp=11", mode_o); end
        total++; if ({alu_enable_o, alu_sel_o, replay_o, counter_clk_en_o, dmr_unrecoverable_o, alu_fail_o} !== '0) begin
            bad++; $display("FAIL reset_outputs en=%b sel=%h cce=%b got nonzero exp zero", alu_enable_o, alu_sel_o, counter_clk_en_o);
        end
        issue_valid_i = 1'b0; rst = 1'b0; sp_m = 0; mode_m = 2'b11;
        #1;
        total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", issue_ready_o); end
    endtask

    task automatic test_back_to_back;
        logic [5:0] exp_sel [5] = '{6'h39, 6'h38, 6'h34, 6'h24, 6'h39};
        logic [3:0] exp_en  [5] = '{4'he, 4'hd, 4'hb, 4'h7, 4'he};
        pf = '0;
        accept_op(0);
        for (int k = 0; k < 5; k++) begin
            total++; if (alu_sel_o !== exp_sel[k] || alu_enable_o !== exp_en[k] || mode_o !== 2'b00) begin
                bad++; $display("FAIL b2b_%0d sel=%h en=%b mode=%b exp sel=%h en=%b mode=00", k, alu_sel_o, alu_enable_o, mode_o, exp_sel[k], exp_en[k]);
            end
            ex_done_i = 1'b1; issue_valid_i = (k < 4); #1;
            total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d got=%b exp=1", k, issue_ready_o); end
            tick();
        end
        ex_done_i = 1'b0; issue_valid_i = 1'b0; sp_m = 1; mode_m = 2'b00;
        total++; if (alu_enable_o !== 4'd0) begin bad++; $display("FAIL b2b_idle_en got=%b exp=0000", alu_enable_o); end
    endtask

    task automatic test_class_fault;
        logic [5:0] s; logic [3:0] e; logic [1:0] m; int n;
        pf = '0; pf[2*NC+5] = 1'b1;
        accept_op(5);
        total++; if (alu_sel_o !== 6'h34 || alu_enable_o !== 4'hb || mode_o !== 2'b00) begin
            bad++; $display("FAIL cls5_tmr sel=%h en=%b mode=%b exp sel=34 en=1011 mode=00", alu_sel_o, alu_enable_o, mode_o);
        end
        ex_done_i = 1'b1; tick(); ex_done_i = 1'b0;
        model(pf, 0, sp_m, s, e, m, n);
        accept_op(0);
        sp_m = (sp_m + 1) % 4;
        total++; if (alu_sel_o !== s || alu_enable_o !== e || mode_o !== m) begin
            bad++; $display("FAIL cls0_after_sel sel=%h en=%b mode=%b exp sel=%h en=%b mode=%b", alu_sel_o, alu_enable_o, mode_o, s, e, m);
        end
        ex_done_i = 1'b1; tick(); ex_done_i = 1'b0;
    endtask

    task automatic test_dmr(input bit second_mismatch);
        pf = '0; pf[0*NC+8] = 1'b1; pf[1*NC+8] = 1'b1;
        accept_op(8);
        mode_m = 2'b01;
        total++; if (alu_sel_o !== 6'b10_11_10 || alu_enable_o !== 4'b1100 || mode_o !== 2'b01 || replay_o !== 1'b0) begin
            bad++; $display("FAIL dmr_sel sel=%h en=%b mode=%b rp=%b exp sel=2e en=1100 mode=01 rp=0", alu_sel_o, alu_enable_o, mode_o, replay_o);
        end
        ex_done_i = 1'b1; vote_mismatch_i = 1'b1; #1;
        total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL dmr_mis_ready got=%b exp=0", issue_ready_o); end
        tick(); ex_done_i = 1'b0; vote_mismatch_i = 1'b0;
        total++; if (alu_enable_o !== 4'd0 || issue_ready_o !== 1'b0) begin
            bad++; $display("FAIL dmr_retry en=%b rdy=%b exp en=0000 rdy=0", alu_enable_o, issue_ready_o);
        end
        tick();
        total++; if (alu_enable_o !== 4'b1100 || replay_o !== 1'b1 || alu_sel_o !== 6'b10_11_10) begin
            bad++; $display("FAIL dmr_replay en=%b rp=%b sel=%h exp en=1100 rp=1 sel=2e", alu_enable_o, replay_o, alu_sel_o);
        end
        ex_done_i = 1'b1; vote_mismatch_i = second_mismatch; tick();
        ex_done_i = 1'b0; vote_mismatch_i = 1'b0;
        if (second_mismatch) begin
            total++; if (dmr_unrecoverable_o !== 1'b1 || issue_ready_o !== 1'b0) begin
                bad++; $display("FAIL dmr_err unrec=%b rdy=%b exp unrec=1 rdy=0", dmr_unrecoverable_o, issue_ready_o);
            end
            tick();
        end
        total++; if (dmr_unrecoverable_o !== 1'b0 || issue_ready_o !== 1'b1 || replay_o !== 1'b0) begin
            bad++; $display("FAIL dmr_end unrec=%b rdy=%b rp=%b exp unrec=0 rdy=1 rp=0", dmr_unrecoverable_o, issue_ready_o, replay_o);
        end
    endtask

    task automatic test_none;
        logic [5:0] s; logic [3:0] e; logic [1:0] m; int n;
        pf = '0; for (int i = 0; i < 4; i++) pf[i*NC+1] = 1'b1;
        accept_op(1);
        mode_m = 2'b11;
        total++; if (alu_fail_o !== 1'b1 || alu_enable_o !== 4'd0 || mode_o !== 2'b11 || issue_ready_o !== 1'b1) begin
            bad++; $display("FAIL none fail=%b en=%b mode=%b rdy=%b exp 1 0000 11 1", alu_fail_o, alu_enable_o, mode_o, issue_ready_o);
        end
        tick();
        total++; if (alu_fail_o !== 1'b0) begin bad++; $display("FAIL none_pulse got=%b exp=0", alu_fail_o); end
        pf = '0; pf[0*NC+8] = 1'b1; pf[1*NC+8] = 1'b1;
        accept_op(8);
        pf = '0; pf[3*NC +: NC] = '1; tick();
        total++; if (alu_sel_o !== 6'b10_11_10 || alu_enable_o !== 4'b1100 || mode_o !== 2'b01) begin
            bad++; $display("FAIL snapshot sel=%h en=%b mode=%b exp sel=2e en=1100 mode=01", alu_sel_o, alu_enable_o, mode_o);
        end
        total++; if (counter_clk_en_o !== 4'b0111) begin bad++; $display("FAIL cce got=%b exp=0111", counter_clk_en_o); end
        ex_done_i = 1'b1; tick(); ex_done_i = 1'b0;
        pf = '0;
        model(pf, 8, sp_m, s, e, m, n);
        accept_op(8);
        sp_m = (sp_m + 1) % 4; mode_m = m;
        total++; if (alu_sel_o !== s || alu_enable_o !== e || mode_o !== m) begin
            bad++; $display("FAIL after_snapshot sel=%h en=%b mode=%b exp sel=%h en=%b mode=%b", alu_sel_o, alu_enable_o, mode_o, s, e, m);
        end
        ex_done_i = 1'b1; tick(); ex_done_i = 1'b0;
        accept_op(12);
        total++; if (mode_o !== mode_m || alu_enable_o !== 4'd0 || alu_fail_o !== 1'b0 || issue_ready_o !== 1'b1) begin
            bad++; $display("FAIL non_alu mode=%b en=%b fail=%b rdy=%b exp mode=%b en=0000 fail=0 rdy=1", mode_o, alu_enable_o, alu_fail_o, issue_ready_o, mode_m);
        end
    endtask

    task automatic test_random;
        logic [35:0] map; logic [5:0] s; logic [3:0] e; logic [1:0] m;
        int cls, n, retries; bit mm, done;
        for (int t = 0; t < 80; t++) begin
            map = '0;
            for (int i = 0; i < 36; i++) map[i] = ($urandom_range(0, 2) == 0);
            cls = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
            pf = map; op_class_i = 4'(cls); issue_valid_i = 1'b1; #1;
            total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL rnd_ready_%0d got=%b exp=1", t, issue_ready_o); end
            tick(); issue_valid_i = 1'b0;
            pf = {4'($urandom), 32'($urandom)};
            if (cls >= NC) begin
                total++; if (mode_o !== mode_m || alu_enable_o !== 4'd0 || alu_fail_o !== 1'b0) begin
                    bad++; $display("FAIL rnd_nonalu_%0d mode=%b en=%b fail=%b exp mode=%b", t, mode_o, alu_enable_o, alu_fail_o, mode_m);
                end
                continue;
            end
            model(map, cls, sp_m, s, e, m, n);
            if (n == 4) sp_m = (sp_m + 1) % 4;
            mode_m = m;
            if (n == 0) begin
                total++; if (alu_fail_o !== 1'b1 || alu_enable_o !== 4'd0 || mode_o !== 2'b11) begin
                    bad++; $display("FAIL rnd_none_%0d fail=%b en=%b mode=%b", t, alu_fail_o, alu_enable_o, mode_o);
                end
                continue;
            end
            total++; if (alu_sel_o !== s || alu_enable_o !== e || mode_o !== m || replay_o !== 1'b0) begin
                bad++; $display("FAIL rnd_sel_%0d sel=%h en=%b mode=%b rp=%b exp sel=%h en=%b mode=%b", t, alu_sel_o, alu_enable_o, mode_o, replay_o, s, e, m);
            end
            retries = 0; done = 0;
            while (!done) begin
                repeat ($urandom_range(0, 3)) begin
                    vote_mismatch_i = $urandom_range(0, 1); #1;
                    total++; if (alu_enable_o !== e || issue_ready_o !== 1'b0) begin
                        bad++; $display("FAIL rnd_hold_%0d en=%b rdy=%b exp en=%b rdy=0", t, alu_enable_o, issue_ready_o, e);
                    end
                    tick();
                end
                mm = $urandom_range(0, 1);
                ex_done_i = 1'b1; vote_mismatch_i = mm; #1;
                if (m == 2'b01 && mm) begin
                    tick(); ex_done_i = 1'b0; vote_mismatch_i = 1'b0;
                    if (retries < MAX_RETRY) begin
                        retries++;
                        total++; if (alu_enable_o !== 4'd0 || issue_ready_o !== 1'b0) begin
                            bad++; $display("FAIL rnd_retry_%0d en=%b rdy=%b exp en=0000 rdy=0", t, alu_enable_o, issue_ready_o);
                        end
                        tick();
                        total++; if (alu_enable_o !== e || replay_o !== 1'b1 || alu_sel_o !== s) begin
                            bad++; $display("FAIL rnd_replay_%0d en=%b rp=%b sel=%h exp en=%b rp=1 sel=%h", t, alu_enable_o, replay_o, alu_sel_o, e, s);
                        end
                    end else begin
                        total++; if (dmr_unrecoverable_o !== 1'b1) begin bad++; $display("FAIL rnd_err_%0d unrec=%b exp=1", t, dmr_unrecoverable_o); end
                        tick();
                        done = 1;
                    end
                end else begin
                    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL rnd_done_%0d rdy=%b exp=1", t, issue_ready_o); end
                    tick(); ex_done_i = 1'b0; vote_mismatch_i = 1'b0;
                    done = 1;
                end
            end
            total++; if (dmr_unrecoverable_o !== 1'b0 || issue_ready_o !== 1'b1 || alu_enable_o !== 4'd0) begin
                bad++; $display("FAIL rnd_idle_%0d unrec=%b rdy=%b en=%b exp 0 1 0000", t, dmr_unrecoverable_o, issue_ready_o, alu_enable_o);
            end
        end
    endtask

    task automatic test_rst_mid;
        pf = '0;
        accept_op(0);
        rst = 1'b1; tick();
        total++; if (alu_enable_o !== 4'd0 || mode_o !== 2'b11 || issue_ready_o !== 1'b0 || alu_fail_o !== 1'b0) begin
            bad++; $display("FAIL rst_mid en=%b mode=%b rdy=%b fail=%b exp 0000 11 0 0", alu_enable_o, mode_o, issue_ready_o, alu_fail_o);
        end
        rst = 1'b0; sp_m = 0;
        accept_op(0);
        total++; if (alu_sel_o !== 6'h39 || alu_enable_o !== 4'he || mode_o !== 2'b00) begin
            bad++; $display("FAIL rst_first sel=%h en=%b mode=%b exp sel=39 en=1110 mode=00", alu_sel_o, alu_enable_o, mode_o);
        end
        ex_done_i = 1'b1; tick(); ex_done_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_class_fault();
        test_dmr(1'b0);
        test_dmr(1'b1);
        test_none();
        test_random();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
